// File: rtl/sr_latch_driver.sv
`default_nettype none
// ============================================================================
//  Module   : sr_latch_driver
//  Purpose  : Valid/ready sequencer that issues one width-controlled set or
//             reset pulse to an SR latch, settles, then checks the readback.
//  Revision : 1.0  initial release
// ============================================================================
module sr_latch_driver #(
    parameter int PULSE_W  = 4,
    parameter int SETTLE_W = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic       i_cmd,
    output logic       o_ready,
    output logic       o_s,
    output logic       o_r,
    input  logic       i_q,
    input  logic       i_qn,
    output logic       o_done,
    output logic       o_err,
    output logic [7:0] o_err_cnt
);

    localparam logic [7:0] c_pulse_load  = 8'(PULSE_W - 1);
    localparam logic [7:0] c_settle_load = 8'(SETTLE_W - 1);
    localparam logic [7:0] c_cnt_max     = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PULSE  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic       r_cmd;
    logic       w_cmd_nxt;
    logic       r_s;
    logic       r_r;
    logic       w_s_nxt;
    logic       w_r_nxt;
    logic       r_done;
    logic       r_err;
    logic [7:0] r_err_cnt;
    logic       w_finish;
    logic       w_readback_ok;

    assign w_finish      = (r_state == ST_SETTLE) && (r_cnt == 8'd0);
    assign w_readback_ok = (i_q == r_cmd) && (i_qn == ~r_cmd);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cmd_nxt   = r_cmd;
        case (r_state)
            ST_IDLE: begin
                if (i_valid) begin
                    w_cmd_nxt   = i_cmd;
                    w_cnt_nxt   = c_pulse_load;
                    w_state_nxt = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (r_cnt == 8'd0) begin
                    w_cnt_nxt   = c_settle_load;
                    w_state_nxt = ST_SETTLE;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Latch drives are decoded from the next state so they are registered yet
    // rise on the accept edge; only one of them can ever be high.
    assign w_s_nxt = (w_state_nxt == ST_PULSE) &&  w_cmd_nxt;
    assign w_r_nxt = (w_state_nxt == ST_PULSE) && !w_cmd_nxt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_cmd   <= 1'b0;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cmd   <= w_cmd_nxt;
            r_s     <= w_s_nxt;
            r_r     <= w_r_nxt;
        end
    end

    // Unknown readback falls into the else branch and is reported as an error.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_finish) begin
                r_done <= 1'b1;
                if (w_readback_ok) begin
                    r_err <= 1'b0;
                end else begin
                    r_err <= 1'b1;
                    if (r_err_cnt != c_cnt_max) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                end
            end
        end
    end

    assign o_ready   = (r_state == ST_IDLE);
    assign o_s       = r_s;
    assign o_r       = r_r;
    assign o_done    = r_done;
    assign o_err     = r_err;
    assign o_err_cnt = r_err_cnt;

endmodule
`default_nettype wire
